// File: rtl/regfile_dbg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dbg
// Brief    : Debug command port that freezes the core, then reads, writes or
//            dumps its integer register file. Define REGFILE_DBG_DUMP_EN to
//            enable the op 10 full-register dump; otherwise op 10 is illegal.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dbg (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [4:0]  dbg_reg,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_valid,
  output logic        dbg_busy,
  output logic        core_stall_req,
  input  logic        core_stall_ack,
  output logic [4:0]  rf_r_name,
  input  logic [31:0] rf_r_val,
  output logic        rf_w_enable,
  output logic [4:0]  rf_w_name,
  output logic [31:0] rf_w_val
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STALL = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DUMP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] C_OP_READ  = 2'b00;
  localparam logic [1:0] C_OP_WRITE = 2'b01;
  localparam logic [1:0] C_OP_DUMP  = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  reg_q, reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        stall_q, stall_d;
  logic        wen_q, wen_d;
  logic [4:0]  wname_q, wname_d;
  logic [31:0] wval_q, wval_d;
  logic [4:0]  rname_q, rname_d;

`ifdef REGFILE_DBG_DUMP_EN
  logic [4:0]  cnt_q, cnt_d;

  // Counter idles at 0 so the first dump cycle always addresses x0.
  always_comb begin
    cnt_d = 5'd0;
    if (state_q == ST_DUMP) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dbg_req) begin
          state_d = ST_STALL;
          op_d    = dbg_op;
          reg_d   = dbg_reg;
          wdata_d = dbg_wdata;
        end
      end
      ST_STALL: begin
        if (core_stall_ack) begin
          case (op_q)
            C_OP_READ:  state_d = ST_READ;
            C_OP_WRITE: state_d = ST_WRITE;
`ifdef REGFILE_DBG_DUMP_EN
            C_OP_DUMP:  state_d = ST_DUMP;
`endif
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_READ: begin
        rdata_d = rf_r_val;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_WRITE: begin
        state_d = ST_DONE;
      end
`ifdef REGFILE_DBG_DUMP_EN
      ST_DUMP: begin
        rdata_d = rf_r_val;
        valid_d = 1'b1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    stall_d = (state_d == ST_STALL) || (state_d == ST_READ) ||
              (state_d == ST_WRITE) || (state_d == ST_DUMP);
    ack_d   = (state_d == ST_DONE);
    wen_d   = (state_d == ST_WRITE) && (reg_d != 5'd0);
    wname_d = wen_d ? reg_d : 5'd0;
    wval_d  = wen_d ? wdata_d : 32'd0;
    rname_d = 5'd0;
    if (state_d == ST_READ) begin
      rname_d = reg_d;
    end
`ifdef REGFILE_DBG_DUMP_EN
    if (state_d == ST_DUMP) begin
      rname_d = cnt_d;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      reg_q   <= 5'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      stall_q <= 1'b0;
      wen_q   <= 1'b0;
      wname_q <= 5'd0;
      wval_q  <= 32'd0;
      rname_q <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      wen_q   <= wen_d;
      wname_q <= wname_d;
      wval_q  <= wval_d;
      rname_q <= rname_d;
    end
  end

  assign dbg_ack        = ack_q;
  assign dbg_rdata      = rdata_q;
  assign dbg_valid      = valid_q;
  assign dbg_busy       = busy_q;
  assign core_stall_req = stall_q;
  assign rf_r_name      = rname_q;
  assign rf_w_enable    = wen_q;
  assign rf_w_name      = wname_q;
  assign rf_w_val       = wval_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dbg.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dbg
// Brief    : Self-checking bench for regfile_dbg with a command-level model
//            and a behavioural register file on the core side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dbg;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req;
  logic [1:0]  dbg_op;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        dbg_valid;
  logic        dbg_busy;
  logic        core_stall_req;
  logic        core_stall_ack;
  logic [4:0]  rf_r_name;
  logic [31:0] rf_r_val;
  logic        rf_w_enable;
  logic [4:0]  rf_w_name;
  logic [31:0] rf_w_val;

  regfile_dbg dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_req        (dbg_req),
    .dbg_op         (dbg_op),
    .dbg_reg        (dbg_reg),
    .dbg_wdata      (dbg_wdata),
    .dbg_ack        (dbg_ack),
    .dbg_rdata      (dbg_rdata),
    .dbg_valid      (dbg_valid),
    .dbg_busy       (dbg_busy),
    .core_stall_req (core_stall_req),
    .core_stall_ack (core_stall_ack),
    .rf_r_name      (rf_r_name),
    .rf_r_val       (rf_r_val),
    .rf_w_enable    (rf_w_enable),
    .rf_w_name      (rf_w_name),
    .rf_w_val       (rf_w_val)
  );

  always #5 clk = ~clk;

  // Core-side register file the DUT talks to.
  logic        rf_clr;
  logic [31:0] env_rf [32];
  assign rf_r_val = env_rf[rf_r_name];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= 32'd0;
    end else if (rf_w_enable) begin
      env_rf[rf_w_name] <= rf_w_val;
    end
  end

  typedef struct packed {
    logic        busy;
    logic        stall;
    logic        ack;
    logic        valid;
    logic        wen;
    logic [4:0]  wname;
    logic [31:0] wval;
    logic [4:0]  rname;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model_rf [32];
  logic [31:0] last_rdata;
  int          n_chk  = 0;
  int          n_fail = 0;

  int          mon_wen = 0, mon_valid = 0, mon_ack = 0, mon_va = 0, mon_stall = 0;
  logic [4:0]  mon_wname;
  logic [31:0] mon_wval;
  logic [31:0] mon_words[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic s, input logic a, input logic v,
                              input logic w, input logic [4:0] wn, input logic [31:0] wv,
                              input logic [4:0] rn, input logic [31:0] rd);
    exp_t e;
    e.busy = b; e.stall = s; e.ack = a; e.valid = v; e.wen = w;
    e.wname = wn; e.wval = wv; e.rname = rn; e.rdata = rd;
    return e;
  endfunction

  // Per-cycle compare plus event monitors.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) e = '0;
    else if (expq.size() > 0) e = expq.pop_front();
    else e = mk(0, 0, 0, 0, 0, 5'd0, 32'd0, 5'd0, last_rdata);
    chk("busy", {31'd0, dbg_busy}, {31'd0, e.busy});
    chk("stall_req", {31'd0, core_stall_req}, {31'd0, e.stall});
    chk("ack", {31'd0, dbg_ack}, {31'd0, e.ack});
    chk("valid", {31'd0, dbg_valid}, {31'd0, e.valid});
    chk("rdata", dbg_rdata, e.rdata);
    chk("w_enable", {31'd0, rf_w_enable}, {31'd0, e.wen});
    chk("r_name", {27'd0, rf_r_name}, {27'd0, e.rname});
    if (e.wen) begin
      chk("w_name", {27'd0, rf_w_name}, {27'd0, e.wname});
      chk("w_val", rf_w_val, e.wval);
    end
    if (rf_w_enable) begin
      mon_wen++;
      mon_wname = rf_w_name;
      mon_wval  = rf_w_val;
    end
    if (dbg_valid) begin
      mon_valid++;
      mon_words.push_back(dbg_rdata);
    end
    if (dbg_ack) mon_ack++;
    if (dbg_ack && dbg_valid) mon_va++;
    if (core_stall_req) mon_stall++;
  end

  // Expected cycle-by-cycle trace of one command, starting with the request cycle.
  task automatic gen_trace(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] wd,
                           input int wt, input bit commit, output int body);
    expq.push_back(mk(0, 0, 0, 0, 0, 5'd0, 32'd0, 5'd0, last_rdata));
    for (int i = 0; i < wt; i++) expq.push_back(mk(1, 1, 0, 0, 0, 5'd0, 32'd0, 5'd0, last_rdata));
    body = 0;
    if (op == 2'b00) begin
      expq.push_back(mk(1, 1, 0, 0, 0, 5'd0, 32'd0, rg, last_rdata));
      last_rdata = model_rf[rg];
      expq.push_back(mk(1, 0, 1, 1, 0, 5'd0, 32'd0, 5'd0, last_rdata));
      body = 1;
    end else if (op == 2'b01) begin
      expq.push_back(mk(1, 1, 0, 0, rg != 5'd0, rg, wd, 5'd0, last_rdata));
      if (commit && rg != 5'd0) model_rf[rg] = wd;
      expq.push_back(mk(1, 0, 1, 0, 0, 5'd0, 32'd0, 5'd0, last_rdata));
      body = 1;
`ifdef REGFILE_DBG_DUMP_EN
    end else if (op == 2'b10) begin
      for (int k = 0; k < 32; k++)
        expq.push_back(mk(1, 1, 0, k > 0, 0, 5'd0, 32'd0, 5'(k), (k > 0) ? model_rf[k-1] : last_rdata));
      last_rdata = model_rf[31];
      expq.push_back(mk(1, 0, 1, 1, 0, 5'd0, 32'd0, 5'd0, last_rdata));
      body = 32;
`endif
    end else begin
      expq.push_back(mk(1, 0, 1, 0, 0, 5'd0, 32'd0, 5'd0, last_rdata));
    end
  endtask

  task automatic abort_reset();
    rst = 1'b1;
    #1;
    chk("rst_stall_req", {31'd0, core_stall_req}, 32'd0);
    chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rst_valid", {31'd0, dbg_valid}, 32'd0);
    chk("rst_w_enable", {31'd0, rf_w_enable}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    expq.delete();
    last_rdata = 32'd0;
    core_stall_ack = 1'b0;
    dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge in an idle cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] wd,
                        input int wt, input bit hold, input int abort_at);
    int body, total;
    gen_trace(op, rg, wd, wt, abort_at == 0, body);
    total = wt + body + 1;
    dbg_op = op; dbg_reg = rg; dbg_wdata = wd; dbg_req = 1'b1;
    @(posedge clk); #1;
    dbg_op = ~op; dbg_reg = ~rg; dbg_wdata = ~wd;
    for (int c = 1; c <= total; c++) begin
      dbg_req = hold && (c < total);
      if (c == abort_at) begin
        abort_reset();
        return;
      end
      core_stall_ack = (c == wt);
      @(posedge clk); #1;
    end
    core_stall_ack = 1'b0;
    dbg_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int b_wen, b_valid, b_ack, b_va, b_stall, ws;
    rst = 1'b1; rf_clr = 1'b1;
    dbg_req = 1'b0; dbg_op = 2'b00; dbg_reg = 5'd0; dbg_wdata = 32'd0; core_stall_ack = 1'b0;
    last_rdata = 32'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, dbg_busy}, 32'd0);
    chk("reset_ack", {31'd0, dbg_ack}, 32'd0);
    chk("reset_rdata", dbg_rdata, 32'd0);
    rst = 1'b0; rf_clr = 1'b0;

    // Write r5 = 0x2A with the core taking three cycles to freeze.
    b_wen = mon_wen; b_ack = mon_ack; b_stall = mon_stall;
    do_cmd(2'b01, 5'd5, 32'h2A, 3, 1'b0, 0);
    chk("w5_pulses", mon_wen - b_wen, 1);
    chk("w5_name", {27'd0, mon_wname}, 5);
    chk("w5_val", mon_wval, 32'h2A);
    chk("w5_stall_cycles", mon_stall - b_stall, 4);
    chk("w5_acks", mon_ack - b_ack, 1);
    chk("w5_env_rf", env_rf[5], 32'h2A);

    // Read r5 back.
    b_valid = mon_valid; b_va = mon_va;
    do_cmd(2'b00, 5'd5, 32'd0, 1, 1'b0, 0);
    chk("r5_valid_cnt", mon_valid - b_valid, 1);
    chk("r5_valid_with_ack", mon_va - b_va, 1);
    chk("r5_rdata", mon_words[$], 32'h2A);

    // x0 write is suppressed but still acknowledged.
    b_wen = mon_wen; b_ack = mon_ack;
    do_cmd(2'b01, 5'd0, 32'hFFFF_FFFF, 2, 1'b1, 0);
    chk("x0_w_pulses", mon_wen - b_wen, 0);
    chk("x0_acks", mon_ack - b_ack, 1);
    do_cmd(2'b00, 5'd0, 32'd0, 1, 1'b0, 0);
    chk("x0_read", mon_words[$], 32'd0);

    // Dump with r3 = 0x35 and r5 = 0x2A.
    do_cmd(2'b01, 5'd3, 32'h35, 1, 1'b0, 0);
    b_valid = mon_valid; b_ack = mon_ack; b_stall = mon_stall; ws = mon_words.size();
    do_cmd(2'b10, 5'd9, 32'd0, 2, 1'b0, 0);
    chk("dump_acks", mon_ack - b_ack, 1);
`ifdef REGFILE_DBG_DUMP_EN
    chk("dump_valid_cnt", mon_valid - b_valid, 32);
    chk("dump_word0", mon_words[ws], 32'd0);
    chk("dump_word3", mon_words[ws+3], 32'h35);
    chk("dump_word5", mon_words[ws+5], 32'h2A);
    chk("dump_word31", mon_words[ws+31], 32'd0);
`else
    chk("dump_off_valid_cnt", mon_valid - b_valid, 0);
    chk("dump_off_stall_cycles", mon_stall - b_stall, 2);
`endif

    // Illegal op leaves rdata from the previous read untouched.
    do_cmd(2'b00, 5'd3, 32'd0, 1, 1'b0, 0);
    b_valid = mon_valid; b_wen = mon_wen;
    do_cmd(2'b11, 5'd3, 32'h1234_5678, 2, 1'b1, 0);
    chk("illegal_valid_cnt", mon_valid - b_valid, 0);
    chk("illegal_w_pulses", mon_wen - b_wen, 0);
    chk("illegal_rdata", dbg_rdata, 32'h35);

    // High register, held request, latched data.
    do_cmd(2'b01, 5'd31, 32'hDEAD_BEEF, 2, 1'b1, 0);
    do_cmd(2'b00, 5'd31, 32'd0, 3, 1'b1, 0);
    chk("r31_rdata", mon_words[$], 32'hDEAD_BEEF);

    // Reset while waiting for the core, then a write dropped mid-flight.
    do_cmd(2'b00, 5'd5, 32'd0, 5, 1'b0, 2);
    do_cmd(2'b01, 5'd7, 32'h0000_1234, 2, 1'b0, 3);
    chk("dropped_write_env", env_rf[7], 32'd0);
    do_cmd(2'b00, 5'd7, 32'd0, 1, 1'b0, 0);
    chk("dropped_write_read", mon_words[$], 32'd0);
`ifdef REGFILE_DBG_DUMP_EN
    do_cmd(2'b10, 5'd0, 32'd0, 1, 1'b0, 12);
`endif
    do_cmd(2'b00, 5'd5, 32'd0, 1, 1'b0, 0);
    chk("post_reset_read", mon_words[$], 32'h2A);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
